// File: rtl/cv32e40x_xif_result_buf.sv
// -----------------------------------------------------------------------------
// cv32e40x_xif_result_buf
//
// In-order result buffer between the AES coprocessor datapath and the
// eXtension-interface result channel. Completed results {data, rd, id} are
// queued in a circular array and presented to the core. in_ready_o depends
// only on registered occupancy, so a stalled core result_ready never reaches
// the AES datapath combinationally.
//
// Optional feature: define XIF_RESULT_BYPASS_EN to let a result arriving at
// an empty buffer appear on out_* in the same cycle. The default build, with
// the macro undefined, has no combinational in_* -> out_* path.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous clear of all entries (wins over push and pop)
//   in_valid_i   coprocessor result valid
//   in_ready_o   buffer can accept a result (= !full)
//   in_data_i    result value
//   in_rd_i      destination register address
//   in_id_i      instruction id
//   out_valid_o  result valid towards the core
//   out_ready_i  core result ready
//   out_data_o   result value at the head
//   out_rd_o     destination register at the head
//   out_id_o     instruction id at the head
//   count_o      number of occupied entries
// -----------------------------------------------------------------------------
module cv32e40x_xif_result_buf #(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFW_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [X_RFW_WIDTH-1:0] in_data_i,
    input  logic [4:0]             in_rd_i,
    input  logic [X_ID_WIDTH-1:0]  in_id_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [X_RFW_WIDTH-1:0] out_data_o,
    output logic [4:0]             out_rd_o,
    output logic [X_ID_WIDTH-1:0]  out_id_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
    logic [4:0]             rd_q   [DEPTH];
    logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic empty;
    logic full;
    logic bypass;
    logic push;
    logic pop;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CntW'(DEPTH));
`ifdef XIF_RESULT_BYPASS_EN
        bypass = empty && in_valid_i;
`else
        bypass = 1'b0;
`endif
        // A bypassed result consumed in the same cycle never touches storage.
        push = in_valid_i && !full && !(bypass && out_ready_i);
        pop  = !empty && out_ready_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is reset so the head reads zero out of reset; flush leaves it intact.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
                id_q[i]   <= '0;
            end
        end else if (push && !flush_i) begin
            data_q[wr_ptr_q] <= in_data_i;
            rd_q[wr_ptr_q]   <= in_rd_i;
            id_q[wr_ptr_q]   <= in_id_i;
        end
    end

    always_comb begin
        in_ready_o = !full;
        count_o    = count_q;
`ifdef XIF_RESULT_BYPASS_EN
        out_valid_o = !empty || bypass;
        if (bypass) begin
            out_data_o = in_data_i;
            out_rd_o   = in_rd_i;
            out_id_o   = in_id_i;
        end else begin
            out_data_o = data_q[rd_ptr_q];
            out_rd_o   = rd_q[rd_ptr_q];
            out_id_o   = id_q[rd_ptr_q];
        end
`else
        out_valid_o = !empty;
        out_data_o  = data_q[rd_ptr_q];
        out_rd_o    = rd_q[rd_ptr_q];
        out_id_o    = id_q[rd_ptr_q];
`endif
    end

endmodule

// File: tb/tb_cv32e40x_xif_result_buf.sv
// Self-checking bench for cv32e40x_xif_result_buf (default build, DEPTH=2).
module tb_cv32e40x_xif_result_buf;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic [4:0]  in_rd_i = '0;
    logic [3:0]  in_id_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic [4:0]  out_rd_o;
    logic [3:0]  out_id_o;
    logic [1:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [40:0] exp_q [$];

    cv32e40x_xif_result_buf #(
        .DEPTH       (2),
        .X_ID_WIDTH  (4),
        .X_RFW_WIDTH (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_rd_i     (in_rd_i),
        .in_id_i     (in_id_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_rd_o    (out_rd_o),
        .out_id_o    (out_id_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake is observed mid-cycle and completes at the next edge.
    always @(negedge clk_i) begin
        if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {23'd0, out_data_o, out_rd_o, out_id_o}, 64'd0);
            end else begin
                check("result", {23'd0, out_data_o, out_rd_o, out_id_o},
                      {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Drive a result for the next edge; record it as expected when it will be accepted.
    task automatic drive(input logic [31:0] d, input logic [4:0] rd, input logic [3:0] id,
                         input bit expect_it);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_rd_i    = rd;
        in_id_i    = id;
        if (expect_it) exp_q.push_back({d, rd, id});
    endtask

    initial begin
        // Reset then idle
        repeat (2) cyc();
        rst_n = 1'b1;
        @(negedge clk_i);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_out_fields", {23'd0, out_data_o, out_rd_o, out_id_o}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk_i);
            check("idle_out_valid", 64'(out_valid_o), 64'd0);
            check("idle_count", 64'(count_o), 64'd0);
        end

        // Single result with out_ready_i high
        cyc();
        out_ready_i = 1'b1;
        drive(32'hDEADBEEF, 5'd10, 4'h3, 1'b1);
        @(negedge clk_i);
        check("single_not_yet_visible", 64'(out_valid_o), 64'd0);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("single_valid", 64'(out_valid_o), 64'd1);
        check("single_count", 64'(count_o), 64'd1);
        cyc();
        @(negedge clk_i);
        check("single_drained_valid", 64'(out_valid_o), 64'd0);
        check("single_drained_count", 64'(count_o), 64'd0);

        // Back-pressure: ids 1, 2 accepted, id 3 refused
        out_ready_i = 1'b0;
        drive(32'h0000_1111, 5'd1, 4'h1, 1'b1);
        cyc();
        drive(32'h0000_2222, 5'd2, 4'h2, 1'b1);
        cyc();
        drive(32'h0000_3333, 5'd3, 4'h3, 1'b0);
        @(negedge clk_i);
        check("bp_in_ready_full", 64'(in_ready_o), 64'd0);
        check("bp_count_full", 64'(count_o), 64'd2);
        check("bp_head_id", 64'(out_id_o), 64'd1);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_count_after_refuse", 64'(count_o), 64'd2);
        check("bp_head_stable", 64'(out_id_o), 64'd1);
        out_ready_i = 1'b1;
        cyc();
        @(negedge clk_i);
        check("bp_in_ready_after_pop", 64'(in_ready_o), 64'd1);
        check("bp_count_after_pop", 64'(count_o), 64'd1);
        cyc();
        @(negedge clk_i);
        check("bp_count_empty", 64'(count_o), 64'd0);

        // Simultaneous push and pop at count=1, eight results across pointer wrap
        out_ready_i = 1'b0;
        drive(32'hA000_0000, 5'd0, 4'h0, 1'b1);
        cyc();
        out_ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            drive(32'hA000_0000 + 32'(i), 5'(i), 4'(i), 1'b1);
            @(negedge clk_i);
            check("pp_count", 64'(count_o), 64'd1);
            cyc();
        end
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("pp_count_tail", 64'(count_o), 64'd1);
        cyc();
        @(negedge clk_i);
        check("pp_count_end", 64'(count_o), 64'd0);

        // Flush while full together with a push
        out_ready_i = 1'b0;
        drive(32'hF000_0004, 5'd4, 4'h4, 1'b1);
        cyc();
        drive(32'hF000_0005, 5'd5, 4'h5, 1'b1);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_count_before", 64'(count_o), 64'd2);
        flush_i = 1'b1;
        drive(32'hF000_0009, 5'd9, 4'h9, 1'b0);
        exp_q.delete();
        cyc();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_count_after", 64'(count_o), 64'd0);
        check("fl_valid_after", 64'(out_valid_o), 64'd0);

        // Flush at count=1 with an otherwise acceptable push: the push is dropped
        drive(32'hF000_0006, 5'd6, 4'h6, 1'b1);
        cyc();
        flush_i = 1'b1;
        drive(32'hF000_0007, 5'd7, 4'h7, 1'b0);
        exp_q.delete();
        cyc();
        flush_i = 1'b0;
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl2_count_after", 64'(count_o), 64'd0);
        check("fl2_valid_after", 64'(out_valid_o), 64'd0);
        out_ready_i = 1'b1;
        drive(32'hF000_000C, 5'd12, 4'hC, 1'b1);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("fl_next_count", 64'(count_o), 64'd1);
        check("fl_next_id", 64'(out_id_o), 64'hC);
        cyc();

        // Asynchronous reset mid-drain
        out_ready_i = 1'b0;
        drive(32'h0BAD_F00D, 5'd17, 4'hA, 1'b0);
        cyc();
        drive(32'h1234_5678, 5'd18, 4'hD, 1'b0);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("ar_valid_before", 64'(out_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid_immediate", 64'(out_valid_o), 64'd0);
        check("ar_count_immediate", 64'(count_o), 64'd0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk_i);
        check("ar_count_after", 64'(count_o), 64'd0);
        check("ar_in_ready_after", 64'(in_ready_o), 64'd1);
        check("ar_out_data_zero", 64'(out_data_o), 64'd0);
        out_ready_i = 1'b1;
        drive(32'hCAFE_0001, 5'd21, 4'hB, 1'b1);
        cyc();
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check("ar_first_push_valid", 64'(out_valid_o), 64'd1);
        cyc();
        @(negedge clk_i);
        check("ar_final_count", 64'(count_o), 64'd0);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
